// File: rtl/fire_control.sv
// Turns the raw fire key into a held, rate-limited fire request with magazine and reload.
// Optional FIRE_CONTROL_AUTO_FIRE_EN: treat the key level as a press while READY.
module fire_control #(
    parameter int FIRE_KEY           = 8,
    parameter int AMMO_MAX           = 5,
    parameter int COOLDOWN_FRAMES    = 8,
    parameter int RELOAD_FRAMES      = 60,
    parameter int REQ_TIMEOUT_FRAMES = 4
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [9:0] keyIsPressed,
    input  logic       startOfFrame,
    input  logic       enable_sof,
    input  logic       proj_active,
    output logic       fire_req,
    output logic [3:0] ammo_count,
    output logic       reloading,
    output logic       ready
);

    typedef enum logic [2:0] {
        S_READY,
        S_REQUEST,
        S_IN_FLIGHT,
        S_COOLDOWN,
        S_RELOAD
    } state_t;

    localparam logic [7:0] REQ_LAST  = 8'(REQ_TIMEOUT_FRAMES - 1);
    localparam logic [7:0] CD_LAST   = 8'((COOLDOWN_FRAMES > 0) ? COOLDOWN_FRAMES - 1 : 0);
    localparam logic [7:0] RL_LAST   = 8'(RELOAD_FRAMES - 1);
    localparam logic [3:0] AMMO_FULL = 4'(AMMO_MAX);

    state_t     state_q, state_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [3:0] ammo_q, ammo_d;
    logic       key_prev_q, key_prev_d;
    logic       fire_req_q, fire_req_d;
    logic       ready_q, ready_d;
    logic       reloading_q, reloading_d;

    logic tick;
    logic key;
    logic press;
    logic cnt_run;
    logic unused_keys;

    assign tick        = startOfFrame & enable_sof;
    assign key         = keyIsPressed[FIRE_KEY];
    assign unused_keys = ^keyIsPressed;
    assign key_prev_d  = key;

`ifdef FIRE_CONTROL_AUTO_FIRE_EN
    assign press = key;
`else
    assign press = key & ~key_prev_q;
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= S_READY;
            frame_cnt_q <= 8'd0;
            ammo_q      <= AMMO_FULL;
            key_prev_q  <= 1'b1;
            fire_req_q  <= 1'b0;
            ready_q     <= 1'b1;
            reloading_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            ammo_q      <= ammo_d;
            key_prev_q  <= key_prev_d;
            fire_req_q  <= fire_req_d;
            ready_q     <= ready_d;
            reloading_q <= reloading_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ammo_d  = ammo_q;
        cnt_run = 1'b0;
        case (state_q)
            S_READY: begin
                // An empty magazine in READY is unreachable; recover by reloading.
                if (ammo_q == 4'd0)
                    state_d = S_RELOAD;
                else if (press)
                    state_d = S_REQUEST;
            end
            S_REQUEST: begin
                // The acknowledge takes priority over a coincident timeout tick.
                if (proj_active) begin
                    state_d = S_IN_FLIGHT;
                    if (ammo_q != 4'd0)
                        ammo_d = ammo_q - 4'd1;
                end else if (tick) begin
                    if (frame_cnt_q == REQ_LAST)
                        state_d = S_READY;
                    else
                        cnt_run = 1'b1;
                end
            end
            S_IN_FLIGHT: begin
                if (!proj_active)
                    state_d = (ammo_q == 4'd0) ? S_RELOAD : S_COOLDOWN;
            end
            S_COOLDOWN: begin
                if (COOLDOWN_FRAMES == 0)
                    state_d = S_READY;
                else if (tick) begin
                    if (frame_cnt_q == CD_LAST)
                        state_d = S_READY;
                    else
                        cnt_run = 1'b1;
                end
            end
            S_RELOAD: begin
                if (tick) begin
                    if (frame_cnt_q == RL_LAST) begin
                        state_d = S_READY;
                        ammo_d  = AMMO_FULL;
                    end else begin
                        cnt_run = 1'b1;
                    end
                end
            end
            default: state_d = S_READY;
        endcase

        // Counter restarts on every state entry and saturates rather than wrapping.
        if (state_d != state_q)
            frame_cnt_d = 8'd0;
        else if (cnt_run && frame_cnt_q != 8'hFF)
            frame_cnt_d = frame_cnt_q + 8'd1;
        else
            frame_cnt_d = frame_cnt_q;
    end

    always_comb begin
        fire_req_d  = (state_d == S_REQUEST);
        ready_d     = (state_d == S_READY);
        reloading_d = (state_d == S_RELOAD);
    end

    assign fire_req   = fire_req_q;
    assign ammo_count = ammo_q;
    assign reloading  = reloading_q;
    assign ready      = ready_q;

endmodule

// File: tb/tb_fire_control.sv
// Directed scenarios plus a random phase, all checked every cycle against a countdown-based model.
module tb_fire_control;

    localparam int AMMO_MAX = 5;
    localparam int CD       = 8;
    localparam int RELOAD   = 60;
    localparam int REQ_TO   = 4;

    logic       clk = 1'b0;
    logic       resetN;
    logic [9:0] keyIsPressed;
    logic       startOfFrame;
    logic       enable_sof;
    logic       proj_active;
    logic       fire_req;
    logic [3:0] ammo_count;
    logic       reloading;
    logic       ready;

    fire_control dut (
        .clk          (clk),
        .resetN       (resetN),
        .keyIsPressed (keyIsPressed),
        .startOfFrame (startOfFrame),
        .enable_sof   (enable_sof),
        .proj_active  (proj_active),
        .fire_req     (fire_req),
        .ammo_count   (ammo_count),
        .reloading    (reloading),
        .ready        (ready)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef enum {M_IDLE, M_WAIT_ACK, M_FLYING, M_COOL, M_REFILL} mmode_t;
    mmode_t m_mode;
    int     m_left;
    int     m_ammo;
    bit     m_kprev;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_left  = 0;
        m_ammo  = AMMO_MAX;
        m_kprev = 1'b1;
    endtask

    // Remaining-tick countdowns per phase; outputs follow the phase entered at this edge.
    task automatic model_edge();
        bit tick, key, press;
        tick = startOfFrame & enable_sof;
        key  = keyIsPressed[8];
`ifdef FIRE_CONTROL_AUTO_FIRE_EN
        press = key;
`else
        press = key & ~m_kprev;
`endif
        m_kprev = key;
        case (m_mode)
            M_IDLE:
                if (m_ammo == 0) begin m_mode = M_REFILL; m_left = RELOAD; end
                else if (press) begin m_mode = M_WAIT_ACK; m_left = REQ_TO; end
            M_WAIT_ACK:
                if (proj_active) begin
                    m_mode = M_FLYING;
                    if (m_ammo > 0) m_ammo--;
                end else if (tick) begin
                    m_left--;
                    if (m_left == 0) m_mode = M_IDLE;
                end
            M_FLYING:
                if (!proj_active) begin
                    if (m_ammo == 0) begin m_mode = M_REFILL; m_left = RELOAD; end
                    else begin m_mode = M_COOL; m_left = CD; end
                end
            M_COOL:
                if (m_left == 0) m_mode = M_IDLE;
                else if (tick) begin
                    m_left--;
                    if (m_left == 0) m_mode = M_IDLE;
                end
            M_REFILL:
                if (tick) begin
                    m_left--;
                    if (m_left == 0) begin m_ammo = AMMO_MAX; m_mode = M_IDLE; end
                end
            default: m_mode = M_IDLE;
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        if (resetN) model_edge(); else model_reset();
        #1;
        chk("m_fire_req", 8'(fire_req), 8'(m_mode == M_WAIT_ACK));
        chk("m_ready", 8'(ready), 8'(m_mode == M_IDLE));
        chk("m_reloading", 8'(reloading), 8'(m_mode == M_REFILL));
        chk("m_ammo", 8'(ammo_count), 8'(m_ammo));
    endtask

    task automatic do_ticks(input int n);
        repeat (n) begin
            step();
            startOfFrame = 1'b1;
            step();
            startOfFrame = 1'b0;
        end
    endtask

    task automatic shot();
        keyIsPressed[8] = 1'b1;
        step();
        proj_active = 1'b1;
        repeat (10) step();
        proj_active     = 1'b0;
        keyIsPressed[8] = 1'b0;
        step();
    endtask

    initial begin
        resetN       = 1'b1;
        keyIsPressed = 10'h100;
        startOfFrame = 1'b0;
        enable_sof   = 1'b1;
        proj_active  = 1'b0;
        #2 resetN = 1'b0;
        #1;
        chk("rst_fire_req", 8'(fire_req), 8'd0);
        chk("rst_ammo", 8'(ammo_count), 8'd5);
        chk("rst_ready", 8'(ready), 8'd1);
        chk("rst_reloading", 8'(reloading), 8'd0);
        model_reset();
        repeat (2) step();
        resetN = 1'b1;

        // key held through reset is not a press
        repeat (3) step();
        chk("held_no_req", 8'(fire_req), 8'd0);
        keyIsPressed[8] = 1'b0;
        step();
        keyIsPressed[8] = 1'b1;
        step();
        chk("press_latency", 8'(fire_req), 8'd1);

        // no acknowledge: dropped on the 4th tick, ticks 100 cycles apart
        for (int i = 0; i < 4; i++) begin
            repeat (99) step();
            startOfFrame = 1'b1;
            step();
            startOfFrame = 1'b0;
            if (i == 2) chk("req_after_3_ticks", 8'(fire_req), 8'd1);
        end
        chk("timeout_drop", 8'(fire_req), 8'd0);
        chk("timeout_ammo", 8'(ammo_count), 8'd5);
        chk("timeout_ready", 8'(ready), 8'd1);
        keyIsPressed[8] = 1'b0;
        step();

        // acknowledge 3 cycles after the request rises
        keyIsPressed[8] = 1'b1;
        step();
        step();
        step();
        chk("req_held_3", 8'(fire_req), 8'd1);
        proj_active = 1'b1;
        step();
        chk("ack_drop", 8'(fire_req), 8'd0);
        chk("ack_ammo", 8'(ammo_count), 8'd4);
        keyIsPressed[8] = 1'b0;
        repeat (9) step();
        proj_active = 1'b0;
        step();
        do_ticks(7);
        chk("cool_not_ready", 8'(ready), 8'd0);
        do_ticks(1);
        chk("cool_ready", 8'(ready), 8'd1);

        // acknowledge coincides with the timeout tick
        keyIsPressed[8] = 1'b1;
        step();
        keyIsPressed[8] = 1'b0;
        do_ticks(3);
        startOfFrame = 1'b1;
        proj_active  = 1'b1;
        step();
        startOfFrame = 1'b0;
        chk("tie_fire_req", 8'(fire_req), 8'd0);
        chk("tie_ammo", 8'(ammo_count), 8'd3);
        chk("tie_ready", 8'(ready), 8'd0);
        repeat (9) step();
        proj_active = 1'b0;
        step();
        do_ticks(8);

        // drain the magazine
        shot(); do_ticks(8);
        shot(); do_ticks(8);
        shot();
        chk("empty_reloading", 8'(reloading), 8'd1);
        chk("empty_ammo", 8'(ammo_count), 8'd0);
        keyIsPressed[8] = 1'b1; step();
        keyIsPressed[8] = 1'b0; step();
        keyIsPressed[8] = 1'b1; step();
        chk("reload_press_ignored", 8'(fire_req), 8'd0);
        keyIsPressed[8] = 1'b0;
        do_ticks(59);
        chk("reload_59", 8'(reloading), 8'd1);
        do_ticks(1);
        chk("reload_ammo", 8'(ammo_count), 8'd5);
        chk("reload_ready", 8'(ready), 8'd1);

        // frozen frame counters
        shot();
        enable_sof = 1'b0;
        do_ticks(20);
        chk("frozen_cool", 8'(ready), 8'd0);
        enable_sof = 1'b1;
        do_ticks(7);
        chk("unfrozen_7", 8'(ready), 8'd0);
        do_ticks(1);
        chk("unfrozen_8", 8'(ready), 8'd1);

        // asynchronous reset mid-request
        keyIsPressed[8] = 1'b1;
        step();
        chk("pre_arst_req", 8'(fire_req), 8'd1);
        resetN = 1'b0;
        #1;
        chk("arst_fire_req", 8'(fire_req), 8'd0);
        chk("arst_ready", 8'(ready), 8'd1);
        model_reset();
        step();
        resetN = 1'b1;
        step();

        // random phase
        for (int i = 0; i < 1500; i++) begin
            logic k;
            k = keyIsPressed[8];
            keyIsPressed = 10'($urandom);
            keyIsPressed[8] = ($urandom_range(0, 3) == 0) ? ~k : k;
            startOfFrame = ($urandom_range(0, 2) == 0);
            enable_sof   = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 7) == 0) proj_active = ~proj_active;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
